// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_if
// Brief    : Pipeline, debug and memory-port signals of the data memory arbiter.
// Revision : 1.0
// ============================================================================
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  pipe_req;
  logic                  pipe_we;
  logic [ADDR_WIDTH-1:0] pipe_addr;
  logic [DATA_WIDTH-1:0] pipe_wdata;
  logic [DATA_WIDTH-1:0] pipe_rdata;
  logic                  pipe_stall;

  logic                  dbg_req;
  logic                  dbg_we;
  logic [ADDR_WIDTH-1:0] dbg_addr;
  logic [DATA_WIDTH-1:0] dbg_wdata;
  logic [DATA_WIDTH-1:0] dbg_rdata;
  logic                  dbg_ack;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // The arbiter serves both requesters and drives the memory port.
  modport slave (
    input  pipe_req, pipe_we, pipe_addr, pipe_wdata,
    output pipe_rdata, pipe_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output pipe_req, pipe_we, pipe_addr, pipe_wdata,
    input  pipe_rdata, pipe_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Sequences one access at a time to the single-port data memory,
//            shared between the MEM stage and the debug unit.
// Revision : 1.0
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int DBG_MAX_WAIT = 8
) (
  input wire            clk,
  input wire            rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic       c_own_pipe = 1'b0;
  localparam logic       c_own_dbg  = 1'b1;
  localparam logic [7:0] c_skip_max = 8'(DBG_MAX_WAIT);
  localparam logic [3:0] c_latency  = 4'(MEM_LATENCY);

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_owner;
  logic [7:0]            r_skip;
  logic [3:0]            r_wait;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [DATA_WIDTH-1:0] r_pipe_rdata;
  logic [DATA_WIDTH-1:0] r_dbg_rdata;

  logic w_grant;
  logic w_dbg_wins;
  logic w_capture;
  logic w_mem_en;
  logic w_dbg_ack;
  logic w_pipe_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_dbg_wins   = 1'b0;
    w_capture    = 1'b0;
    w_mem_en     = 1'b0;
    w_dbg_ack    = 1'b0;
    w_pipe_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.pipe_req || bus.dbg_req) begin
          w_grant      = 1'b1;
          // Debug only overtakes a waiting pipeline once it has been skipped enough times.
          w_dbg_wins   = bus.dbg_req && (!bus.pipe_req || (r_skip == c_skip_max));
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_mem_en     = 1'b1;
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_wait == 4'd1) begin
          w_capture    = !r_mem_we;
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_dbg_ack    = (r_owner == c_own_dbg);
        w_pipe_done  = (r_owner == c_own_pipe);
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner      <= c_own_pipe;
      r_skip       <= '0;
      r_wait       <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_pipe_rdata <= '0;
      r_dbg_rdata  <= '0;
    end else begin
      if (w_grant) begin
        r_owner     <= w_dbg_wins ? c_own_dbg : c_own_pipe;
        r_mem_we    <= w_dbg_wins ? bus.dbg_we    : bus.pipe_we;
        r_mem_addr  <= w_dbg_wins ? bus.dbg_addr  : bus.pipe_addr;
        r_mem_wdata <= w_dbg_wins ? bus.dbg_wdata : bus.pipe_wdata;
        if (w_dbg_wins) begin
          r_skip <= '0;
        end else if (bus.dbg_req && (r_skip != c_skip_max)) begin
          r_skip <= r_skip + 8'd1;
        end
      end

      if (r_state == ST_ISSUE) begin
        r_wait <= c_latency;
      end else if (r_state == ST_WAIT) begin
        r_wait <= r_wait - 4'd1;
      end

      if (w_capture) begin
        if (r_owner == c_own_dbg) begin
          r_dbg_rdata <= bus.mem_rdata;
        end else begin
          r_pipe_rdata <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.mem_en     = w_mem_en;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.pipe_rdata = r_pipe_rdata;
  assign bus.dbg_rdata  = r_dbg_rdata;
  assign bus.dbg_ack    = w_dbg_ack;
  // Stall is released combinationally in DONE so the pipeline advances on that edge.
  assign bus.pipe_stall = bus.pipe_req & ~w_pipe_done & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Randomised and directed bench for dmem_arbiter against a
//            transaction-level reference model.
// Revision : 1.0
// ============================================================================
module tb_dmem_arbiter;
  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int LAT      = 2;
  localparam int MAXW     = 2;
  localparam int MEMW     = 64;
  localparam int DONE_POS = LAT + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  dmem_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .MEM_LATENCY (LAT),
    .DBG_MAX_WAIT(MAXW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input logic [5:0] a);
    return 32'hA5A5_0000 | {26'd0, a};
  endfunction

  // Memory behind the port: data is only valid in the cycle it must be sampled.
  logic [DW-1:0]   mem [MEMW];
  logic [MEMW-1:0] mem_wr = '0;
  int              rd_cnt = 0;
  logic [5:0]      rd_idx = '0;

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) begin
      mem[bus.mem_addr[5:0]]    <= bus.mem_wdata;
      mem_wr[bus.mem_addr[5:0]] <= 1'b1;
    end
    if (bus.mem_en && !bus.mem_we) begin
      rd_cnt <= LAT;
      rd_idx <= bus.mem_addr[5:0];
    end else if (rd_cnt > 0) begin
      rd_cnt <= rd_cnt - 1;
    end
  end

  assign bus.mem_rdata = (rd_cnt == 1) ? (mem_wr[rd_idx] ? mem[rd_idx] : init_val(rd_idx))
                                       : 32'hBAD0_BAD0;

  // Reference model: position within the current access (0 = free).
  logic [DW-1:0] model_mem [logic [AW-1:0]];
  int            pos     = 0;
  bit            own_dbg = 1'b0;
  int            skip    = 0;
  bit            l_we    = 1'b0;
  logic [AW-1:0] l_addr  = '0;
  logic [DW-1:0] l_wdata = '0;
  logic [DW-1:0] exp_prd = '0;
  logic [DW-1:0] exp_drd = '0;

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_val(a[5:0]);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pos     = 0;
      own_dbg = 1'b0;
      skip    = 0;
      exp_prd = '0;
      exp_drd = '0;
    end else if (pos == 0) begin
      if (bus.pipe_req || bus.dbg_req) begin
        own_dbg = bus.dbg_req && (!bus.pipe_req || skip == MAXW);
        if (own_dbg) skip = 0;
        else if (bus.dbg_req) skip = (skip + 1 > MAXW) ? MAXW : skip + 1;
        l_we    = own_dbg ? bus.dbg_we    : bus.pipe_we;
        l_addr  = own_dbg ? bus.dbg_addr  : bus.pipe_addr;
        l_wdata = own_dbg ? bus.dbg_wdata : bus.pipe_wdata;
        pos     = 1;
      end
    end else begin
      if (pos == 1 && l_we) model_mem[l_addr] = l_wdata;
      if (pos == LAT + 1 && !l_we) begin
        if (own_dbg) exp_drd = model_read(l_addr);
        else         exp_prd = model_read(l_addr);
      end
      pos = (pos == DONE_POS) ? 0 : pos + 1;
    end
  end

  int            cyc = 0;
  logic [AW-1:0] grant_addr [$];
  int            grant_cyc  [$];

  always @(negedge clk) begin
    cyc++;
    chk("mem_en", bus.mem_en, pos == 1);
    if (pos == 1) begin
      chk("mem_we", bus.mem_we, l_we);
      chk("mem_addr", bus.mem_addr, l_addr);
      if (l_we) chk("mem_wdata", bus.mem_wdata, l_wdata);
    end
    chk("pipe_stall", bus.pipe_stall, bus.pipe_req && !rst && !(pos == DONE_POS && !own_dbg));
    chk("dbg_ack", bus.dbg_ack, pos == DONE_POS && own_dbg);
    chk("pipe_rdata", bus.pipe_rdata, exp_prd);
    chk("dbg_rdata", bus.dbg_rdata, exp_drd);
    if (bus.mem_en) begin
      grant_addr.push_back(bus.mem_addr);
      grant_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pipe_op(input bit we, input logic [5:0] a, input logic [DW-1:0] d,
                         output int stall_n);
    bit done = 1'b0;
    stall_n        = 0;
    bus.pipe_we    = we;
    bus.pipe_addr  = AW'(a);
    bus.pipe_wdata = d;
    bus.pipe_req   = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      #2;
      if (bus.pipe_stall) begin
        stall_n++;
        tick();
      end else begin
        done = 1'b1;
      end
    end
    bus.pipe_req = 1'b0;
    chk("pipe_op_completes", done, 1'b1);
    tick();
  endtask

  task automatic dbg_op(input bit we, input logic [5:0] a, input logic [DW-1:0] d);
    bit done = 1'b0;
    bus.dbg_we    = we;
    bus.dbg_addr  = AW'(a);
    bus.dbg_wdata = d;
    bus.dbg_req   = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      #2;
      if (bus.dbg_ack) done = 1'b1;
      else tick();
    end
    bus.dbg_req = 1'b0;
    chk("dbg_op_completes", done, 1'b1);
    tick();
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  logic [AW-1:0] rr_exp [6];
  int            n0, sn, acks, en_n, st_n, ack_n;
  bit            pd, dd;

  initial begin
    bus.pipe_req = 1'b0; bus.pipe_we = 1'b0; bus.pipe_addr = '0; bus.pipe_wdata = '0;
    bus.dbg_req  = 1'b0; bus.dbg_we  = 1'b0; bus.dbg_addr  = '0; bus.dbg_wdata  = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    // Reset state, and stall is gated while reset is held.
    bus.pipe_req = 1'b1;
    #1;
    chk("rst_pipe_stall", bus.pipe_stall, 1'b0);
    chk("rst_mem_en", bus.mem_en, 1'b0);
    chk("rst_pipe_rdata", bus.pipe_rdata, 32'd0);
    chk("rst_dbg_rdata", bus.dbg_rdata, 32'd0);
    bus.pipe_req = 1'b0;
    rst = 1'b0;
    tick();

    // Store then load through the pipeline.
    n0 = grant_addr.size();
    pipe_op(1'b1, 6'd0, 32'd3, sn);
    chk("store_stall_cycles", sn, 4);
    pipe_op(1'b0, 6'd0, 32'd0, sn);
    chk("load_stall_cycles", sn, 4);
    chk("load_pipe_rdata", bus.pipe_rdata, 32'd3);
    chk("store_load_mem_en_pulses", grant_addr.size() - n0, 2);

    // Simultaneous requests: pipeline first, debug one IDLE cycle later.
    n0 = grant_addr.size();
    bus.pipe_we = 1'b0; bus.pipe_addr = 32'd4; bus.pipe_req = 1'b1;
    bus.dbg_we  = 1'b0; bus.dbg_addr  = 32'd0; bus.dbg_req  = 1'b1;
    pd = 1'b0; dd = 1'b0;
    for (int i = 0; i < 60 && !(pd && dd); i++) begin
      #2;
      if (bus.pipe_req && !bus.pipe_stall) begin bus.pipe_req = 1'b0; pd = 1'b1; end
      if (bus.dbg_ack) begin bus.dbg_req = 1'b0; dd = 1'b1; end
      tick();
    end
    chk("simul_grants", grant_addr.size() - n0, 2);
    if (grant_addr.size() - n0 == 2) begin
      chk("simul_first_pipe", grant_addr[n0], 32'd4);
      chk("simul_second_dbg", grant_addr[n0+1], 32'd0);
      chk("simul_issue_spacing", grant_cyc[n0+1] - grant_cyc[n0], 5);
    end
    chk("simul_pipe_rdata", bus.pipe_rdata, 32'hA5A5_0004);
    chk("simul_dbg_rdata", bus.dbg_rdata, 32'd3);

    // Both held: debug forced in after every two pipeline grants.
    rr_exp[0] = 32'd8; rr_exp[1] = 32'd8; rr_exp[2] = 32'd60;
    rr_exp[3] = 32'd8; rr_exp[4] = 32'd8; rr_exp[5] = 32'd60;
    n0 = grant_addr.size();
    acks = 0;
    bus.pipe_we = 1'b0; bus.pipe_addr = 32'd8;  bus.pipe_req = 1'b1;
    bus.dbg_we  = 1'b0; bus.dbg_addr  = 32'd60; bus.dbg_req  = 1'b1;
    for (int i = 0; i < 200 && acks < 2; i++) begin
      #2;
      if (bus.dbg_ack) acks++;
      if (acks == 2) begin bus.pipe_req = 1'b0; bus.dbg_req = 1'b0; end
      tick();
    end
    bus.pipe_req = 1'b0; bus.dbg_req = 1'b0;
    chk("rr_grant_count", grant_addr.size() - n0, 6);
    if (grant_addr.size() - n0 == 6) begin
      for (int k = 0; k < 6; k++) chk($sformatf("rr_grant_%0d", k), grant_addr[n0+k], rr_exp[k]);
    end
    chk("rr_skip_cleared", dut.r_skip, 8'd0);
    chk("rr_dbg_rdata", bus.dbg_rdata, 32'hA5A5_003C);
    repeat (2) tick();

    // Debug write leaves dbg_rdata alone; pipeline then reads it back.
    dbg_op(1'b1, 6'd4, 32'd7);
    chk("dbg_write_rdata_held", bus.dbg_rdata, 32'hA5A5_003C);
    pipe_op(1'b0, 6'd4, 32'd0, sn);
    chk("readback_pipe_rdata", bus.pipe_rdata, 32'd7);

    // Reset in the middle of a debug read.
    n0 = grant_addr.size();
    bus.dbg_we = 1'b0; bus.dbg_addr = 32'd12; bus.dbg_req = 1'b1;
    for (int i = 0; i < 20 && pos != 2; i++) tick();
    chk("rst_test_reached_wait", pos, 2);
    rst = 1'b1;
    #1;
    chk("midrst_mem_en", bus.mem_en, 1'b0);
    chk("midrst_dbg_ack", bus.dbg_ack, 1'b0);
    chk("midrst_pipe_rdata", bus.pipe_rdata, 32'd0);
    chk("midrst_dbg_rdata", bus.dbg_rdata, 32'd0);
    chk("midrst_state_idle", dut.r_state, 64'd0);
    ack_n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      if (bus.dbg_ack) ack_n++;
    end
    chk("midrst_no_ack", ack_n, 0);
    tick();
    rst = 1'b0;
    dbg_op(1'b0, 6'd12, 32'd0);
    chk("rerun_dbg_rdata", bus.dbg_rdata, 32'hA5A5_000C);
    chk("rerun_mem_en_pulses", grant_addr.size() - n0, 2);

    // Quiet period.
    en_n = 0; st_n = 0; ack_n = 0;
    for (int i = 0; i < 20; i++) begin
      #2;
      if (bus.mem_en) en_n++;
      if (bus.pipe_stall) st_n++;
      if (bus.dbg_ack) ack_n++;
      tick();
    end
    chk("idle_mem_en", en_n, 0);
    chk("idle_pipe_stall", st_n, 0);
    chk("idle_dbg_ack", ack_n, 0);

    // Random traffic obeying the hold-until-complete rule.
    for (int c = 0; c < 1500; c++) begin
      if (!bus.pipe_req || (pos == DONE_POS && !own_dbg)) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.pipe_we    = 1'($urandom_range(0, 1));
          bus.pipe_addr  = AW'($urandom_range(0, 15));
          bus.pipe_wdata = $urandom;
          bus.pipe_req   = 1'b1;
        end else begin
          bus.pipe_req = 1'b0;
        end
      end
      if (!bus.dbg_req || (pos == DONE_POS && own_dbg)) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.dbg_we    = 1'($urandom_range(0, 1));
          bus.dbg_addr  = AW'($urandom_range(0, 15));
          bus.dbg_wdata = $urandom;
          bus.dbg_req   = 1'b1;
        end else begin
          bus.dbg_req = 1'b0;
        end
      end
      tick();
    end
    for (int i = 0; i < 40 && pos != DONE_POS; i++) tick();
    bus.pipe_req = 1'b0;
    bus.dbg_req  = 1'b0;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
